// File: rtl/reg_file_operand_stage.sv
// Purpose : NREG x WIDTH register file (r0 reads 0) with bypassed dual read ports feeding a one-deep ALU operand latch.
// Latency : read address -> out_data0/1 and out_alu_sel is 1 clock; write -> same-cycle read is 0 clocks (bypass).
// Backpressure: stall holds the latch (writes still land in the file), flush inserts a bubble, reset overrides both.
module reg_file_operand_stage #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             in_valid,
  input  logic [2:0]       alu_sel_in,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [2:0]       out_alu_sel,
  output logic             out_valid
);

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  // Register array: cleared on reset (pending write dropped); writeback never touches r0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: r0 forced to zero, then same-cycle write bypass, then stored value.
  always_comb begin
    rd1 = regs[rd_addr1];
    rd2 = regs[rd_addr2];
    if (rd_addr1 == '0) begin
      rd1 = '0;
    end else if (wr_en && (wr_addr == rd_addr1)) begin
      rd1 = wr_data;
    end
    if (rd_addr2 == '0) begin
      rd2 = '0;
    end else if (wr_en && (wr_addr == rd_addr2)) begin
      rd2 = wr_data;
    end
  end

  // Operand latch: reset > flush > stall > load; data is loaded even for invalid slots.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_data0   <= '0;
      out_data1   <= '0;
      out_alu_sel <= '0;
      out_valid   <= 1'b0;
    end else if (flush) begin
      out_data0   <= '0;
      out_data1   <= '0;
      out_alu_sel <= '0;
      out_valid   <= 1'b0;
    end else if (!stall) begin
      out_data0   <= rd1;
      out_data1   <= rd2;
      out_alu_sel <= alu_sel_in;
      out_valid   <= in_valid;
    end
  end

endmodule

// File: tb/tb_reg_file_operand_stage.sv
// Purpose : exercises reg_file_operand_stage with directed cases then random traffic against a reference model.
// Latency : model predicts the latch contents one clock after inputs are applied.
// Backpressure: random stall/flush/reset mixed into the traffic.
module tb_reg_file_operand_stage;

  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int AW    = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             in_valid;
  logic [2:0]       alu_sel_in;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [2:0]       out_alu_sel;
  logic             out_valid;

  reg_file_operand_stage #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .in_valid    (in_valid),
    .alu_sel_in  (alu_sel_in),
    .stall       (stall),
    .flush       (flush),
    .out_data0   (out_data0),
    .out_data1   (out_data1),
    .out_alu_sel (out_alu_sel),
    .out_valid   (out_valid)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: register contents and the expected latch view.
  logic [WIDTH-1:0] mem [NREG];
  logic [WIDTH-1:0] exp_d0;
  logic [WIDTH-1:0] exp_d1;
  logic [2:0]       exp_sel;
  logic             exp_vld;
  bit               data_defined;

  function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic we, input int wa, input logic [WIDTH-1:0] wd,
                        input int a1, input int a2, input logic iv, input int sel,
                        input logic st, input logic fl);
    reset      = rst;
    wr_en      = we;
    wr_addr    = AW'(wa);
    wr_data    = wd;
    rd_addr1   = AW'(a1);
    rd_addr2   = AW'(a2);
    in_valid   = iv;
    alu_sel_in = 3'(sel);
    stall      = st;
    flush      = fl;
  endtask

  // Predict the edge from the current inputs, clock it, then compare one step after the edge.
  task automatic step(input string tag);
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    r1 = model_read(rd_addr1);
    r2 = model_read(rd_addr2);
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem[i] = '0;
      exp_d0 = '0; exp_d1 = '0; exp_sel = '0; exp_vld = 1'b0; data_defined = 1'b1;
    end else begin
      if (flush) begin
        exp_d0 = '0; exp_d1 = '0; exp_sel = '0; exp_vld = 1'b0; data_defined = 1'b1;
      end else if (!stall) begin
        exp_d0 = r1; exp_d1 = r2; exp_sel = alu_sel_in; exp_vld = in_valid;
        data_defined = in_valid;
      end
      if (wr_en && wr_addr != 0) mem[wr_addr] = wr_data;
    end
    @(posedge clock);
    #1;
    check({tag, ".valid"}, 32'(out_valid), 32'(exp_vld));
    if (data_defined) begin
      check({tag, ".d0"},  32'(out_data0),   32'(exp_d0));
      check({tag, ".d1"},  32'(out_data1),   32'(exp_d1));
      check({tag, ".sel"}, 32'(out_alu_sel), 32'(exp_sel));
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) mem[i] = 'x;
    exp_d0 = 'x; exp_d1 = 'x; exp_sel = 'x; exp_vld = 1'bx; data_defined = 1'b0;

    // 1 Reset, then read every register through both ports.
    set_in(1'b0, 1'b0, 0, 16'h0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    step("reset");
    for (int i = 0; i < NREG; i++) begin
      set_in(1'b1, 1'b0, 0, 16'h0, i, NREG - 1 - i, 1'b1, 0, 1'b0, 1'b0);
      step("rst_read");
    end

    // 2 Write r1=4, r2=7, then read them.
    set_in(1'b1, 1'b1, 1, 16'd4, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    step("wr_r1");
    set_in(1'b1, 1'b1, 2, 16'd7, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    step("wr_r2");
    set_in(1'b1, 1'b0, 0, 16'h0, 1, 2, 1'b1, 0, 1'b0, 1'b0);
    step("rd_r1_r2");

    // 3 Same-cycle bypass on both ports.
    set_in(1'b1, 1'b1, 3, 16'h00FF, 3, 3, 1'b1, 2, 1'b0, 1'b0);
    step("bypass");

    // 4 Writes to r0 are dropped; r0 bypass must not apply.
    set_in(1'b1, 1'b1, 0, 16'hFFFF, 0, 0, 1'b1, 3, 1'b0, 1'b0);
    step("r0_wr");
    set_in(1'b1, 1'b0, 0, 16'h0, 0, 0, 1'b1, 4, 1'b0, 1'b0);
    step("r0_rd");

    // 5 Load, stall while writing r1, flush beats stall, reload sees new r1.
    set_in(1'b1, 1'b0, 0, 16'h0, 1, 2, 1'b1, 1, 1'b0, 1'b0);
    step("load");
    set_in(1'b1, 1'b1, 1, 16'd9, 2, 1, 1'b0, 4, 1'b1, 1'b0);
    step("stall1");
    step("stall2");
    set_in(1'b1, 1'b0, 0, 16'h0, 1, 2, 1'b1, 1, 1'b1, 1'b1);
    step("flush");
    set_in(1'b1, 1'b0, 0, 16'h0, 1, 2, 1'b1, 1, 1'b0, 1'b0);
    step("reload");

    // 6 Reset while stalled and writing: everything clears, write discarded.
    set_in(1'b0, 1'b1, 5, 16'hBEEF, 1, 5, 1'b1, 2, 1'b1, 1'b0);
    step("mid_reset");
    set_in(1'b1, 1'b0, 0, 16'h0, 5, 1, 1'b1, 2, 1'b0, 1'b0);
    step("post_reset");

    // Random traffic with occasional stall, flush and reset.
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 49) != 0),
             1'($urandom_range(0, 1)),
             int'($urandom_range(0, NREG - 1)),
             WIDTH'($urandom),
             int'($urandom_range(0, NREG - 1)),
             int'($urandom_range(0, NREG - 1)),
             1'($urandom_range(0, 1)),
             int'($urandom_range(0, 4)),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) == 0));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
